// File: rtl/run_monitor_pkg.sv
// ============================================================================
// Module   : run_monitor_pkg
// Brief    : State encodings and default parameters shared by run_monitor.
// Revision : 1.0
// ============================================================================
`default_nettype none

package run_monitor_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUN     = 2'd1,
        S_HALT    = 2'd2,
        S_TIMEOUT = 2'd3
    } run_state_t;

    localparam int unsigned c_def_xlen        = 32;
    localparam int unsigned c_def_cnt_w       = 32;
    localparam int unsigned c_def_max_cycles  = 500;
    localparam int unsigned c_def_end_pc      = 0;
    localparam int unsigned c_def_stall_limit = 8;

endpackage

`default_nettype wire

// File: rtl/run_monitor_sat_counter.sv
// ============================================================================
// Module   : sat_counter
// Brief    : Up-counter with synchronous clear and saturation at all-ones.
//            o_next exposes the value that will be loaded on the next edge.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sat_counter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_en,
    output logic [WIDTH-1:0] o_count,
    output logic [WIDTH-1:0] o_next
);

    logic [WIDTH-1:0] r_count;

    // Clear wins over enable so a restart on the same cycle always zeroes.
    always_comb begin
        o_next = r_count;
        if (i_clr) begin
            o_next = '0;
        end else if (i_en && (r_count != '1)) begin
            o_next = r_count + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else begin
            r_count <= o_next;
        end
    end

    assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/run_monitor.sv
// ============================================================================
// Module   : run_monitor
// Brief    : Watches a CPU program counter and ends a run on END_PC, a
//            self-loop stall, or a cycle timeout. Optional retired-instruction
//            counter is enabled by defining RUN_MONITOR_INSTRET_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module run_monitor
    import run_monitor_pkg::*;
#(
    parameter int unsigned      XLEN        = c_def_xlen,
    parameter int unsigned      CNT_W       = c_def_cnt_w,
    parameter int unsigned      MAX_CYCLES  = c_def_max_cycles,
    parameter logic [XLEN-1:0]  END_PC      = XLEN'(c_def_end_pc),
    parameter int unsigned      STALL_LIMIT = c_def_stall_limit
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [XLEN-1:0]  pc,
    input  logic             retire,
    output logic [1:0]       state,
    output logic             stop_req,
    output logic [CNT_W-1:0] cycle_count,
    output logic [XLEN-1:0]  final_pc
`ifdef RUN_MONITOR_INSTRET_EN
    ,
    output logic [CNT_W-1:0] instret
`endif
);

    run_state_t       r_state;
    logic             r_stop_req;
    logic [XLEN-1:0]  r_final_pc;
    logic [XLEN-1:0]  r_prev_pc;
    logic             r_pc_valid;

    logic             w_run;
    logic             w_count_en;
    logic             w_pc_same;
    logic             w_end_hit;
    logic             w_stall_hit;
    logic             w_timeout_hit;
    logic [CNT_W-1:0] w_cycle_next;
    logic [CNT_W-1:0] w_stall_count;
    logic [CNT_W-1:0] w_stall_next;
    logic             w_unused_ok;

    assign w_run      = (r_state == S_RUN);
    // A start pulse in RUN is a restart cycle, not a counted RUN cycle.
    assign w_count_en = w_run && !start;
    assign w_pc_same  = r_pc_valid && (pc == r_prev_pc);

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_cycle_cnt (
        .clk     (clk),
        .rst_n   (reset),
        .i_clr   (start),
        .i_en    (w_count_en),
        .o_count (cycle_count),
        .o_next  (w_cycle_next)
    );

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_stall_cnt (
        .clk     (clk),
        .rst_n   (reset),
        .i_clr   (start || (w_count_en && !w_pc_same)),
        .i_en    (w_count_en && w_pc_same),
        .o_count (w_stall_count),
        .o_next  (w_stall_next)
    );

    // Terminations are judged on the counter values this cycle will produce.
    assign w_end_hit     = (pc == END_PC);
    assign w_stall_hit   = (STALL_LIMIT != 0) && (w_stall_next == CNT_W'(STALL_LIMIT));
    assign w_timeout_hit = (w_cycle_next == CNT_W'(MAX_CYCLES));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_stop_req <= 1'b0;
            r_final_pc <= '0;
            r_prev_pc  <= '0;
            r_pc_valid <= 1'b0;
        end else begin
            r_stop_req <= 1'b0;
            if (start) begin
                r_state    <= S_RUN;
                r_final_pc <= '0;
                r_prev_pc  <= '0;
                r_pc_valid <= 1'b0;
            end else if (r_state == S_RUN) begin
                r_prev_pc  <= pc;
                r_pc_valid <= 1'b1;
                if (w_end_hit || w_stall_hit) begin
                    r_state    <= S_HALT;
                    r_stop_req <= 1'b1;
                    r_final_pc <= pc;
                end else if (w_timeout_hit) begin
                    r_state    <= S_TIMEOUT;
                    r_stop_req <= 1'b1;
                    r_final_pc <= pc;
                end
            end
        end
    end

    assign state    = r_state;
    assign stop_req = r_stop_req;
    assign final_pc = r_final_pc;

`ifdef RUN_MONITOR_INSTRET_EN
    logic [CNT_W-1:0] w_instret_next;

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_instret_cnt (
        .clk     (clk),
        .rst_n   (reset),
        .i_clr   (start),
        .i_en    (w_count_en && retire),
        .o_count (instret),
        .o_next  (w_instret_next)
    );

    assign w_unused_ok = ^{w_stall_count, w_instret_next};
`else
    assign w_unused_ok = ^{w_stall_count, retire};
`endif

endmodule

`default_nettype wire

// File: tb/tb_run_monitor.sv
// ============================================================================
// Module   : tb_run_monitor
// Brief    : Directed self-checking bench for run_monitor (and the
//            RUN_MONITOR_INSTRET_EN build when that macro is defined).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_run_monitor;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] pc;
    logic        retire;
    logic [1:0]  state,       state2;
    logic        stop_req,    stop_req2;
    logic [31:0] cycle_count, cycle_count2;
    logic [31:0] final_pc,    final_pc2;
`ifdef RUN_MONITOR_INSTRET_EN
    logic [31:0] instret,     instret2;
`endif

    int n_tests   = 0;
    int n_fail    = 0;
    int stop_cnt  = 0;
    int stop_cnt2 = 0;

    run_monitor #(
        .XLEN(32), .CNT_W(32), .MAX_CYCLES(500), .END_PC(32'h40), .STALL_LIMIT(8)
    ) u_dut (
        .clk(clk), .reset(reset), .start(start), .pc(pc), .retire(retire),
        .state(state), .stop_req(stop_req), .cycle_count(cycle_count), .final_pc(final_pc)
`ifdef RUN_MONITOR_INSTRET_EN
        , .instret(instret)
`endif
    );

    // Short timeout so END_PC/stall can coincide with timeout on one cycle.
    run_monitor #(
        .XLEN(32), .CNT_W(32), .MAX_CYCLES(9), .END_PC(32'h40), .STALL_LIMIT(8)
    ) u_dut2 (
        .clk(clk), .reset(reset), .start(start), .pc(pc), .retire(retire),
        .state(state2), .stop_req(stop_req2), .cycle_count(cycle_count2), .final_pc(final_pc2)
`ifdef RUN_MONITOR_INSTRET_EN
        , .instret(instret2)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input logic [31:0] p, input logic r);
        pc     = p;
        retire = r;
        @(posedge clk);
        #1;
        if (stop_req)  stop_cnt++;
        if (stop_req2) stop_cnt2++;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (stop_req)  stop_cnt++;
        if (stop_req2) stop_cnt2++;
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; pc = '0; retire = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_tests++; if (state !== 2'd0) begin n_fail++; $display("FAIL rst_state: got %0d want 0", state); end
        n_tests++; if (stop_req !== 1'b0) begin n_fail++; $display("FAIL rst_stop: got %b want 0", stop_req); end
        n_tests++; if (cycle_count !== 32'd0) begin n_fail++; $display("FAIL rst_count: got %0d want 0", cycle_count); end
        n_tests++; if (final_pc !== 32'd0) begin n_fail++; $display("FAIL rst_final_pc: got %h want 0", final_pc); end
`ifdef RUN_MONITOR_INSTRET_EN
        n_tests++; if (instret !== 32'd0) begin n_fail++; $display("FAIL rst_instret: got %0d want 0", instret); end
`endif
        reset = 1'b1;
    endtask

    task automatic test_idle_ignore();
        stop_cnt = 0;
        for (int i = 0; i < 3; i++) step(32'h40, 1'b1);
        n_tests++; if (state !== 2'd0) begin n_fail++; $display("FAIL idle_state: got %0d want 0", state); end
        n_tests++; if (cycle_count !== 32'd0) begin n_fail++; $display("FAIL idle_count: got %0d want 0", cycle_count); end
        n_tests++; if (stop_cnt !== 0) begin n_fail++; $display("FAIL idle_stops: got %0d want 0", stop_cnt); end
    endtask

    task automatic test_end_pc();
        stop_cnt = 0;
        do_start();
        n_tests++; if (state !== 2'd1) begin n_fail++; $display("FAIL start_state: got %0d want 1", state); end
        n_tests++; if (cycle_count !== 32'd0) begin n_fail++; $display("FAIL start_count: got %0d want 0", cycle_count); end
        for (int i = 0; i < 16; i++) step(32'(4 * i), 1'b0);
        n_tests++; if (state !== 2'd1) begin n_fail++; $display("FAIL end_pre_state: got %0d want 1", state); end
        n_tests++; if (cycle_count !== 32'd16) begin n_fail++; $display("FAIL end_pre_count: got %0d want 16", cycle_count); end
        step(32'h40, 1'b0);
        n_tests++; if (state !== 2'd2) begin n_fail++; $display("FAIL end_state: got %0d want 2", state); end
        n_tests++; if (stop_req !== 1'b1) begin n_fail++; $display("FAIL end_stop: got %b want 1", stop_req); end
        n_tests++; if (cycle_count !== 32'd17) begin n_fail++; $display("FAIL end_count: got %0d want 17", cycle_count); end
        n_tests++; if (final_pc !== 32'h40) begin n_fail++; $display("FAIL end_final_pc: got %h want 40", final_pc); end
        step(32'h44, 1'b1);
        step(32'h48, 1'b1);
        n_tests++; if (state !== 2'd2) begin n_fail++; $display("FAIL end_hold_state: got %0d want 2", state); end
        n_tests++; if (cycle_count !== 32'd17) begin n_fail++; $display("FAIL end_hold_count: got %0d want 17", cycle_count); end
        n_tests++; if (final_pc !== 32'h40) begin n_fail++; $display("FAIL end_hold_pc: got %h want 40", final_pc); end
        n_tests++; if (stop_cnt !== 1) begin n_fail++; $display("FAIL end_stops: got %0d want 1", stop_cnt); end
    endtask

    task automatic test_stall();
        stop_cnt = 0; stop_cnt2 = 0;
        do_start();
        for (int i = 0; i < 8; i++) step(32'h20, 1'b0);
        n_tests++; if (state !== 2'd1) begin n_fail++; $display("FAIL stall_pre_state: got %0d want 1", state); end
        n_tests++; if (cycle_count !== 32'd8) begin n_fail++; $display("FAIL stall_pre_count: got %0d want 8", cycle_count); end
        step(32'h20, 1'b0);
        n_tests++; if (state !== 2'd2) begin n_fail++; $display("FAIL stall_state: got %0d want 2", state); end
        n_tests++; if (cycle_count !== 32'd9) begin n_fail++; $display("FAIL stall_count: got %0d want 9", cycle_count); end
        n_tests++; if (final_pc !== 32'h20) begin n_fail++; $display("FAIL stall_final_pc: got %h want 20", final_pc); end
        n_tests++; if (stop_cnt !== 1) begin n_fail++; $display("FAIL stall_stops: got %0d want 1", stop_cnt); end
        // Stall limit and timeout land on the same cycle in the short instance.
        n_tests++; if (state2 !== 2'd2) begin n_fail++; $display("FAIL stall_vs_timeout_state: got %0d want 2", state2); end
        n_tests++; if (cycle_count2 !== 32'd9) begin n_fail++; $display("FAIL stall_vs_timeout_count: got %0d want 9", cycle_count2); end
        n_tests++; if (stop_cnt2 !== 1) begin n_fail++; $display("FAIL stall_vs_timeout_stops: got %0d want 1", stop_cnt2); end
    endtask

    task automatic test_priority();
        stop_cnt = 0; stop_cnt2 = 0;
        do_start();
        for (int i = 0; i < 8; i++) step(32'h20, 1'b0);
        step(32'h40, 1'b0);
        step(32'h40, 1'b0);
        n_tests++; if (state !== 2'd2) begin n_fail++; $display("FAIL prio_state: got %0d want 2", state); end
        n_tests++; if (final_pc !== 32'h40) begin n_fail++; $display("FAIL prio_final_pc: got %h want 40", final_pc); end
        n_tests++; if (cycle_count !== 32'd9) begin n_fail++; $display("FAIL prio_count: got %0d want 9", cycle_count); end
        n_tests++; if (stop_cnt !== 1) begin n_fail++; $display("FAIL prio_stops: got %0d want 1", stop_cnt); end
        n_tests++; if (state2 !== 2'd2) begin n_fail++; $display("FAIL prio_end_vs_timeout_state: got %0d want 2", state2); end
        n_tests++; if (final_pc2 !== 32'h40) begin n_fail++; $display("FAIL prio_end_vs_timeout_pc: got %h want 40", final_pc2); end
        n_tests++; if (stop_cnt2 !== 1) begin n_fail++; $display("FAIL prio_end_vs_timeout_stops: got %0d want 1", stop_cnt2); end
    endtask

    task automatic test_timeout();
        stop_cnt = 0;
        do_start();
        for (int i = 0; i < 499; i++) step(32'h1000 + 32'(4 * i), 1'b0);
        n_tests++; if (state !== 2'd1) begin n_fail++; $display("FAIL to_pre_state: got %0d want 1", state); end
        n_tests++; if (cycle_count !== 32'd499) begin n_fail++; $display("FAIL to_pre_count: got %0d want 499", cycle_count); end
        n_tests++; if (state2 !== 2'd3) begin n_fail++; $display("FAIL to_short_state: got %0d want 3", state2); end
        n_tests++; if (cycle_count2 !== 32'd9) begin n_fail++; $display("FAIL to_short_count: got %0d want 9", cycle_count2); end
        n_tests++; if (final_pc2 !== 32'h1020) begin n_fail++; $display("FAIL to_short_pc: got %h want 1020", final_pc2); end
        step(32'h17cc, 1'b0);
        n_tests++; if (state !== 2'd3) begin n_fail++; $display("FAIL to_state: got %0d want 3", state); end
        n_tests++; if (stop_req !== 1'b1) begin n_fail++; $display("FAIL to_stop: got %b want 1", stop_req); end
        n_tests++; if (cycle_count !== 32'd500) begin n_fail++; $display("FAIL to_count: got %0d want 500", cycle_count); end
        n_tests++; if (final_pc !== 32'h17cc) begin n_fail++; $display("FAIL to_final_pc: got %h want 17cc", final_pc); end
        step(32'h17d0, 1'b0);
        n_tests++; if (cycle_count !== 32'd500) begin n_fail++; $display("FAIL to_hold_count: got %0d want 500", cycle_count); end
        n_tests++; if (stop_cnt !== 1) begin n_fail++; $display("FAIL to_stops: got %0d want 1", stop_cnt); end
    endtask

    task automatic test_restart();
        do_start();
        for (int i = 0; i < 5; i++) step(32'h100 + 32'(4 * i), 1'b0);
        n_tests++; if (cycle_count !== 32'd5) begin n_fail++; $display("FAIL rs_pre_count: got %0d want 5", cycle_count); end
        do_start();
        n_tests++; if (state !== 2'd1) begin n_fail++; $display("FAIL rs_state: got %0d want 1", state); end
        n_tests++; if (cycle_count !== 32'd0) begin n_fail++; $display("FAIL rs_count: got %0d want 0", cycle_count); end
        for (int i = 0; i < 3; i++) step(32'h100 + 32'(4 * i), 1'b0);
        n_tests++; if (cycle_count !== 32'd3) begin n_fail++; $display("FAIL rs_post_count: got %0d want 3", cycle_count); end
    endtask

    task automatic test_async_reset();
        stop_cnt = 0;
        do_start();
        for (int i = 0; i < 100; i++) step(32'h2000 + 32'(4 * i), 1'b1);
        n_tests++; if (cycle_count !== 32'd100) begin n_fail++; $display("FAIL ar_pre_count: got %0d want 100", cycle_count); end
        #2;
        reset = 1'b0;
        #1;
        n_tests++; if (state !== 2'd0) begin n_fail++; $display("FAIL ar_state: got %0d want 0", state); end
        n_tests++; if (cycle_count !== 32'd0) begin n_fail++; $display("FAIL ar_count: got %0d want 0", cycle_count); end
        n_tests++; if (stop_req !== 1'b0) begin n_fail++; $display("FAIL ar_stop: got %b want 0", stop_req); end
`ifdef RUN_MONITOR_INSTRET_EN
        n_tests++; if (instret !== 32'd0) begin n_fail++; $display("FAIL ar_instret: got %0d want 0", instret); end
`endif
        @(posedge clk);
        #3;
        reset = 1'b1;
        step(32'h2400, 1'b0);
        step(32'h2404, 1'b0);
        n_tests++; if (state !== 2'd0) begin n_fail++; $display("FAIL ar_idle_state: got %0d want 0", state); end
        n_tests++; if (stop_cnt !== 0) begin n_fail++; $display("FAIL ar_stops: got %0d want 0", stop_cnt); end
        do_start();
        step(32'h3000, 1'b0);
        n_tests++; if (state !== 2'd1) begin n_fail++; $display("FAIL ar_rerun_state: got %0d want 1", state); end
        n_tests++; if (cycle_count !== 32'd1) begin n_fail++; $display("FAIL ar_rerun_count: got %0d want 1", cycle_count); end
    endtask

`ifdef RUN_MONITOR_INSTRET_EN
    task automatic test_instret();
        do_start();
        n_tests++; if (instret !== 32'd0) begin n_fail++; $display("FAIL ir_start: got %0d want 0", instret); end
        for (int i = 0; i < 400; i++) step(32'h4000 + 32'(4 * i), ((i % 4) != 3));
        n_tests++; if (instret !== 32'd300) begin n_fail++; $display("FAIL ir_count: got %0d want 300", instret); end
        step(32'h40, 1'b0);
        n_tests++; if (state !== 2'd2) begin n_fail++; $display("FAIL ir_state: got %0d want 2", state); end
        n_tests++; if (cycle_count !== 32'd401) begin n_fail++; $display("FAIL ir_cycles: got %0d want 401", cycle_count); end
        for (int i = 0; i < 3; i++) step(32'h44, 1'b1);
        n_tests++; if (instret !== 32'd300) begin n_fail++; $display("FAIL ir_frozen: got %0d want 300", instret); end
    endtask
`endif

    initial begin
        test_reset();
        test_idle_ignore();
        test_end_pc();
        test_stall();
        test_priority();
        test_timeout();
        test_restart();
        test_async_reset();
`ifdef RUN_MONITOR_INSTRET_EN
        test_instret();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
